// File: rtl/vga_capture_monitor.sv
// vga_capture_monitor: rebuilds pixel coordinates from VGA syncs, checks line/frame timing, locks, and checksums each frame.
// Ports: clk; reset (async, active-low); p_tick pixel-rate enable; hsync/vsync/red/green/blue sampled on p_tick;
//        pix_x/pix_y/pix_rgb/pix_valid recovered active pixel; locked timing lock; line_err violation pulse while locked;
//        frame_count/frame_sum/sum_valid completed-frame count and checksum.
module vga_capture_monitor #(
  parameter int H_TOTAL         = 800,
  parameter int V_TOTAL         = 525,
  parameter int H_START         = 144,
  parameter int V_START         = 35,
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        pix_valid,
  output logic        locked,
  output logic        line_err,
  output logic [15:0] frame_count,
  output logic [15:0] frame_sum,
  output logic        sum_valid
);
  localparam logic [10:0] HT1 = 11'(H_TOTAL - 1);
  localparam logic [10:0] HS  = 11'(H_START);
  localparam logic [10:0] HE  = 11'(H_START + H_ACTIVE);
  localparam logic [9:0]  VS  = 10'(V_START);
  localparam logic [9:0]  VE  = 10'(V_START + V_ACTIVE);
  localparam logic [10:0] VT  = 11'(V_TOTAL);
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_e;
  state_e state_q, state_d;
  logic hs_a, vs_a, hs_q, hs_d, vs_q, vs_d, hs_edge, vs_edge;
  logic [10:0] h_cnt_q, h_cnt_d, line_cnt_q, line_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic first_q, first_d, err_q, err_d;
  logic [15:0] acc_q, acc_d, acc_sum;
  logic act, line_viol, miss_h, frame_ok, lock_fail, clean_v;
  logic locked_s, err_pulse, do_sum, err_set, to_search;
  logic [9:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [11:0] pix_rgb_q, pix_rgb_d;
  logic pix_valid_q, pix_valid_d, line_err_q, line_err_d, sum_valid_q, sum_valid_d;
  logic [15:0] frame_count_q, frame_count_d, frame_sum_q, frame_sum_d;
  // Syncs are normalised to "1 = asserted" so edge logic is polarity independent.
  assign hs_a    = SYNC_ACTIVE_LOW ? ~hsync : hsync;
  assign vs_a    = SYNC_ACTIVE_LOW ? ~vsync : vsync;
  assign hs_edge = p_tick & hs_a & ~hs_q;
  assign vs_edge = p_tick & vs_a & ~vs_q;
  always_comb begin
    hs_d       = p_tick ? hs_a : hs_q;
    vs_d       = p_tick ? vs_a : vs_q;
    h_cnt_d    = !p_tick ? h_cnt_q : hs_edge ? 11'd0 : (&h_cnt_q) ? h_cnt_q : h_cnt_q + 11'd1;
    v_cnt_d    = vs_edge ? 10'd0 : hs_edge ? v_cnt_q + 10'd1 : v_cnt_q;
    // Lines per frame: the hsync edge sharing a tick with vsync belongs to the new frame.
    line_cnt_d = vs_edge ? {10'd0, hs_edge} : (hs_edge && !(&line_cnt_q)) ? line_cnt_q + 11'd1 : line_cnt_q;
    line_viol  = hs_edge & ~first_q & (h_cnt_q != HT1);
    miss_h     = p_tick & ~hs_edge & (h_cnt_q == HT1);
    frame_ok   = line_cnt_q == VT;
    lock_fail  = line_viol | miss_h | (vs_edge & ~frame_ok);
    clean_v    = ~err_q & ~line_viol & frame_ok;
    act        = (h_cnt_d >= HS) & (h_cnt_d < HE) & (v_cnt_d >= VS) & (v_cnt_d < VE);
    acc_sum    = acc_q + (act ? {4'd0, red, green, blue} : 16'd0);
    acc_d      = vs_edge ? 16'd0 : p_tick ? acc_sum : acc_q;
    first_d    = to_search ? 1'b1 : hs_edge ? 1'b0 : first_q;
    err_d      = vs_edge ? 1'b0 : err_set ? 1'b1 : err_q;
    pix_valid_d   = p_tick & locked_s & act;
    pix_x_d       = pix_valid_d ? 10'(h_cnt_d - HS) : pix_x_q;
    pix_y_d       = pix_valid_d ? v_cnt_d - VS : pix_y_q;
    pix_rgb_d     = pix_valid_d ? {red, green, blue} : pix_rgb_q;
    line_err_d    = err_pulse;
    sum_valid_d   = do_sum;
    frame_sum_d   = do_sum ? acc_sum : frame_sum_q;
    frame_count_d = do_sum ? frame_count_q + 16'd1 : frame_count_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= SEARCH;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEARCH:  state_d = vs_edge ? VERIFY : SEARCH;
      VERIFY:  state_d = (vs_edge && clean_v) ? LOCKED : VERIFY;
      LOCKED:  state_d = lock_fail ? SEARCH : LOCKED;
      default: state_d = SEARCH;
    endcase
  end
  always_comb begin
    locked_s  = state_q == LOCKED;
    err_pulse = locked_s & lock_fail;
    do_sum    = locked_s & vs_edge & ~lock_fail;
    err_set   = (state_q == VERIFY) & line_viol;
    to_search = (state_d == SEARCH) & (state_q != SEARCH);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      line_cnt_q    <= '0;
      first_q       <= 1'b1;
      err_q         <= 1'b0;
      acc_q         <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
      pix_valid_q   <= 1'b0;
      line_err_q    <= 1'b0;
      sum_valid_q   <= 1'b0;
      frame_sum_q   <= '0;
      frame_count_q <= '0;
    end else begin
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      line_cnt_q    <= line_cnt_d;
      first_q       <= first_d;
      err_q         <= err_d;
      acc_q         <= acc_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_rgb_q     <= pix_rgb_d;
      pix_valid_q   <= pix_valid_d;
      line_err_q    <= line_err_d;
      sum_valid_q   <= sum_valid_d;
      frame_sum_q   <= frame_sum_d;
      frame_count_q <= frame_count_d;
    end
  end
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;
  assign pix_valid   = pix_valid_q;
  assign locked      = state_q == LOCKED;
  assign line_err    = line_err_q;
  assign frame_count = frame_count_q;
  assign frame_sum   = frame_sum_q;
  assign sum_valid   = sum_valid_q;
endmodule

// File: tb/tb_vga_capture_monitor.sv
// tb_vga_capture_monitor: directed scenarios on a reduced 20x12 timing (10x6 active) for both sync polarities.
module tb_vga_capture_monitor;
  localparam int HT = 20, VT = 12, HS = 5, VS = 3, HA = 10, VA = 6;
  localparam logic [15:0] WHITE_SUM = 16'hBFC4;
  logic clk = 1'b0, reset = 1'b1, p_tick = 1'b0, hs_a = 1'b0, vs_a = 1'b0;
  logic [3:0] red = '0, green = '0, blue = '0;
  logic [9:0] pix_x, pix_y, pix_x2, pix_y2;
  logic [11:0] pix_rgb, pix_rgb2;
  logic pix_valid, locked, line_err, sum_valid, pix_valid2, locked2, line_err2, sum_valid2;
  logic [15:0] frame_count, frame_sum, frame_count2, frame_sum2;
  int tests = 0, fails = 0;
  int n_pix = 0, n_nz = 0, n_err = 0, n_sum = 0, n_sum2 = 0, n_err2 = 0;
  logic [9:0] last_x = '0, last_y = '0, nz_x = '0, nz_y = '0;
  logic [11:0] last_rgb = '0, nz_rgb = '0;
  logic [15:0] last_sum = '0, last_fc = '0, last_sum2 = '0, last_fc2 = '0;
  logic err_lock = 1'b1;
  time t_hit = 0, err_time = 0;
  always #5 clk = ~clk;
  vga_capture_monitor #(.H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .SYNC_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(~hs_a), .vsync(~vs_a), .red(red), .green(green), .blue(blue),
    .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .pix_valid(pix_valid), .locked(locked), .line_err(line_err),
    .frame_count(frame_count), .frame_sum(frame_sum), .sum_valid(sum_valid));
  vga_capture_monitor #(.H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .SYNC_ACTIVE_LOW(1'b0)) dut2 (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hs_a), .vsync(vs_a), .red(red), .green(green), .blue(blue),
    .pix_x(pix_x2), .pix_y(pix_y2), .pix_rgb(pix_rgb2), .pix_valid(pix_valid2), .locked(locked2), .line_err(line_err2),
    .frame_count(frame_count2), .frame_sum(frame_sum2), .sum_valid(sum_valid2));
  always @(negedge clk) begin
    if (pix_valid) begin
      n_pix++; last_x = pix_x; last_y = pix_y; last_rgb = pix_rgb;
      if (pix_rgb != 12'h000) begin n_nz++; nz_x = pix_x; nz_y = pix_y; nz_rgb = pix_rgb; end
    end
    if (line_err) begin n_err++; err_lock = locked; err_time = $time; end
    if (sum_valid) begin n_sum++; last_sum = frame_sum; last_fc = frame_count; end
    if (sum_valid2) begin n_sum2++; last_sum2 = frame_sum2; last_fc2 = frame_count2; end
    if (line_err2) n_err2++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
  task automatic tick(input logic h, input logic v, input logic [11:0] rgb);
    hs_a = h; vs_a = v; {red, green, blue} = rgb; p_tick = 1'b1;
    @(negedge clk);
    p_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic gen_frame(input int lines, input int long_v, input int long_len, input bit one_px, output logic lk0);
    lk0 = 1'bx;
    for (int v = 0; v < lines; v++) begin
      for (int h = 0; h < ((v == long_v) ? long_len : HT); h++) begin
        if (v == long_v && h == HT) t_hit = $time;
        tick(h < 3, v < 2, one_px ? ((h == HS && v == VS) ? 12'h123 : 12'h000) : 12'hFFF);
        if (v == 0 && h == 0) lk0 = locked;
      end
    end
  endtask
  task automatic test_reset;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if ({pix_x, pix_y, pix_rgb, pix_valid, locked, line_err, frame_count, frame_sum, sum_valid} !== '0) begin
      fails++; $display("FAIL reset_outputs: got x=%0d y=%0d rgb=%h v=%b lk=%b le=%b fc=%h fs=%h sv=%b want all 0",
        pix_x, pix_y, pix_rgb, pix_valid, locked, line_err, frame_count, frame_sum, sum_valid); end
    tests++; if ({locked2, frame_count2, frame_sum2, sum_valid2, pix_valid2} !== '0) begin
      fails++; $display("FAIL reset_outputs_pos: got lk=%b fc=%h fs=%h want 0", locked2, frame_count2, frame_sum2); end
    reset = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_lock_and_sum;
    logic lk; int s, p;
    s = n_sum;
    gen_frame(VT, -1, 0, 1'b0, lk);
    tests++; if (lk !== 1'b0) begin fails++; $display("FAIL lock_edge1: locked=%b want 0", lk); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL lock_verify: locked=%b want 0", locked); end
    gen_frame(VT, -1, 0, 1'b0, lk);
    tests++; if (lk !== 1'b1) begin fails++; $display("FAIL lock_edge2: locked=%b want 1", lk); end
    p = n_pix;
    for (int f = 1; f <= 3; f++) begin
      gen_frame(VT, -1, 0, 1'b0, lk);
      tests++; if (n_sum !== s + f) begin fails++; $display("FAIL white_sum_cnt%0d: got %0d want %0d", f, n_sum - s, f); end
      tests++; if (last_sum !== WHITE_SUM) begin fails++; $display("FAIL white_sum%0d: got %h want %h", f, last_sum, WHITE_SUM); end
      tests++; if (last_fc !== 16'(f)) begin fails++; $display("FAIL white_fc%0d: got %0d want %0d", f, last_fc, f); end
      if (f == 1) begin
        tests++; if (n_pix - p !== HA * VA) begin fails++; $display("FAIL pix_count: got %0d want %0d", n_pix - p, HA * VA); end
        tests++; if ({last_x, last_y, last_rgb} !== {10'd9, 10'd5, 12'hFFF}) begin
          fails++; $display("FAIL last_pix: got (%0d,%0d)=%h want (9,5)=fff", last_x, last_y, last_rgb); end
      end
    end
    tests++; if (n_err !== 0) begin fails++; $display("FAIL clean_no_err: got %0d want 0", n_err); end
  endtask
  task automatic test_polarity;
    tests++; if (n_sum2 !== 3) begin fails++; $display("FAIL pos_sum_cnt: got %0d want 3", n_sum2); end
    tests++; if (last_sum2 !== WHITE_SUM) begin fails++; $display("FAIL pos_sum: got %h want %h", last_sum2, WHITE_SUM); end
    tests++; if (last_fc2 !== 16'd3) begin fails++; $display("FAIL pos_fc: got %0d want 3", last_fc2); end
    tests++; if (locked2 !== 1'b1 || n_err2 !== 0) begin fails++; $display("FAIL pos_lock: locked=%b errs=%0d want 1,0", locked2, n_err2); end
  endtask
  task automatic test_single_pixel;
    logic lk; int z;
    z = n_nz;
    gen_frame(VT, -1, 0, 1'b1, lk);
    tests++; if (n_nz - z !== 1) begin fails++; $display("FAIL one_px_cnt: got %0d want 1", n_nz - z); end
    tests++; if ({nz_x, nz_y, nz_rgb} !== {10'd0, 10'd0, 12'h123}) begin
      fails++; $display("FAIL one_px: got (%0d,%0d)=%h want (0,0)=123", nz_x, nz_y, nz_rgb); end
    gen_frame(VT, -1, 0, 1'b0, lk);
    tests++; if (last_sum !== 16'h0123) begin fails++; $display("FAIL one_px_sum: got %h want 0123", last_sum); end
    tests++; if (last_fc !== 16'd5) begin fails++; $display("FAIL one_px_fc: got %0d want 5", last_fc); end
  endtask
  task automatic test_long_line;
    logic lk; int s, e; logic [15:0] fc;
    s = n_sum; e = n_err;
    gen_frame(VT, 4, HT + 1, 1'b0, lk);
    tests++; if (n_err !== e + 1) begin fails++; $display("FAIL long_err_cnt: got %0d want 1", n_err - e); end
    tests++; if (err_lock !== 1'b0) begin fails++; $display("FAIL long_lock_drop: locked=%b at line_err want 0", err_lock); end
    tests++; if (err_time !== t_hit + 10) begin fails++; $display("FAIL long_err_time: got %0t want %0t", err_time, t_hit + 10); end
    tests++; if (n_sum !== s + 1) begin fails++; $display("FAIL long_prev_sum: got %0d want 1", n_sum - s); end
    fc = frame_count;
    gen_frame(VT, -1, 0, 1'b0, lk);
    tests++; if (lk !== 1'b0) begin fails++; $display("FAIL long_relock1: locked=%b want 0", lk); end
    gen_frame(VT, -1, 0, 1'b0, lk);
    tests++; if (lk !== 1'b1) begin fails++; $display("FAIL long_relock2: locked=%b want 1", lk); end
    tests++; if (n_sum !== s + 1 || frame_count !== fc) begin
      fails++; $display("FAIL long_no_sum: sums=%0d fc=%0d want 1,%0d", n_sum - s, frame_count, fc); end
  endtask
  task automatic test_short_frame;
    logic lk; int s, e; logic [15:0] fc;
    gen_frame(VT - 1, -1, 0, 1'b0, lk);
    s = n_sum; e = n_err; fc = frame_count;
    gen_frame(VT, -1, 0, 1'b0, lk);
    tests++; if (lk !== 1'b0) begin fails++; $display("FAIL short_unlock: locked=%b want 0", lk); end
    tests++; if (n_err !== e + 1 || err_lock !== 1'b0) begin
      fails++; $display("FAIL short_err: errs=%0d lock_at_err=%b want 1,0", n_err - e, err_lock); end
    tests++; if (n_sum !== s || frame_count !== fc) begin
      fails++; $display("FAIL short_no_sum: sums=%0d fc=%0d want 0,%0d", n_sum - s, frame_count, fc); end
    gen_frame(VT, -1, 0, 1'b0, lk);
    gen_frame(VT, -1, 0, 1'b0, lk);
    tests++; if (lk !== 1'b1) begin fails++; $display("FAIL short_relock: locked=%b want 1", lk); end
  endtask
  task automatic test_missing_hsync;
    logic lk; int e;
    e = n_err;
    gen_frame(VT, 4, 903, 1'b0, lk);
    tests++; if (n_err !== e + 1) begin fails++; $display("FAIL miss_err_cnt: got %0d want 1", n_err - e); end
    tests++; if (err_time !== t_hit + 10) begin fails++; $display("FAIL miss_err_time: got %0t want %0t", err_time, t_hit + 10); end
    tests++; if (locked !== 1'b0 || err_lock !== 1'b0) begin
      fails++; $display("FAIL miss_search: locked=%b lock_at_err=%b want 0,0", locked, err_lock); end
  endtask
  task automatic test_reset_mid;
    logic lk;
    gen_frame(VT, -1, 0, 1'b0, lk);
    gen_frame(VT, -1, 0, 1'b0, lk);
    gen_frame(6, -1, 0, 1'b0, lk);
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL mid_prelock: locked=%b want 1", locked); end
    reset = 1'b0;
    #1;
    tests++; if ({pix_x, pix_y, pix_rgb, pix_valid, locked, line_err, frame_count, frame_sum, sum_valid} !== '0) begin
      fails++; $display("FAIL mid_reset_outputs: got x=%0d y=%0d rgb=%h lk=%b fc=%h fs=%h want all 0",
        pix_x, pix_y, pix_rgb, locked, frame_count, frame_sum); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    gen_frame(VT, -1, 0, 1'b0, lk);
    tests++; if (lk !== 1'b0) begin fails++; $display("FAIL mid_relock1: locked=%b want 0", lk); end
    gen_frame(VT, -1, 0, 1'b0, lk);
    tests++; if (lk !== 1'b1) begin fails++; $display("FAIL mid_relock2: locked=%b want 1", lk); end
    gen_frame(VT, -1, 0, 1'b0, lk);
    tests++; if (last_fc !== 16'd1 || last_sum !== WHITE_SUM) begin
      fails++; $display("FAIL mid_first_sum: fc=%0d sum=%h want 1,%h", last_fc, last_sum, WHITE_SUM); end
  endtask
  initial begin
    test_reset;
    test_lock_and_sum;
    test_polarity;
    test_single_pixel;
    test_long_line;
    test_short_frame;
    test_missing_hsync;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_capture_monitor.md
Name: vga_capture_monitor

Overview:
- Receive-side counterpart of the team's VGA output path. Samples hsync/vsync/RGB on pixel ticks and rebuilds pixel coordinates from the sync pulses alone.
- Checks line and frame timing, and declares lock once a full frame matches.
- Produces a per-frame RGB checksum. Used in on-chip loopback and self-check of the display and text-overlay output.

Parameters:
- H_TOTAL, 800, pixel ticks per line
- V_TOTAL, 525, lines per frame
- H_START, 144, h_cnt value of the first active pixel (sync + back porch)
- V_START, 35, v_cnt value of the first active line
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- SYNC_ACTIVE_LOW, 1, 1 means hsync/vsync assert low

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- p_tick  in  1  pixel-rate enable, one clk wide
- hsync  in  1  horizontal sync
- vsync  in  1  vertical sync
- red  in  4  pixel red
- green  in  4  pixel green
- blue  in  4  pixel blue
- pix_x  out  10  recovered column
- pix_y  out  10  recovered row
- pix_rgb  out  12  {red,green,blue} of that pixel
- pix_valid  out  1  one-clk pulse: pix_x/pix_y/pix_rgb hold an active pixel
- locked  out  1  timing lock
- line_err  out  1  one-clk pulse on a timing violation while LOCKED
- frame_count  out  16  completed locked frames, wraps
- frame_sum  out  16  checksum of the last completed locked frame
- sum_valid  out  1  one-clk pulse when frame_sum updates

Behaviour:
- Reset: all outputs are 0; counters, accumulator and edge registers cleared; FSM enters SEARCH.
- Sampling:
  - All state advances only on clk cycles with p_tick=1.
  - Sync edges are detected against the previous p_tick sample.
  - An "assertion edge" is a transition to the asserted level, as selected by SYNC_ACTIVE_LOW.
- h_cnt (11 bit):
  - Set to 0 on an hsync assertion edge; otherwise +1.
  - Saturates at 2047.
- v_cnt (10 bit):
  - Set to 0 on a vsync assertion edge.
  - Otherwise +1 on an hsync assertion edge.
  - If both edges occur in the same tick, the vsync rule wins.
- Active window: H_START <= h_cnt < H_START+H_ACTIVE and V_START <= v_cnt < V_START+V_ACTIVE.
  - pix_x = h_cnt - H_START, pix_y = v_cnt - V_START.
- Pixel output:
  - Registered; valid 1 clk after the sampling tick.
  - pix_valid = 1 only when locked and in the active window.
  - pix_x, pix_y and pix_rgb hold their values between pulses.
- Line check:
  - On each hsync assertion edge, the previous h_cnt+1 must equal H_TOTAL.
  - This check is skipped for the first hsync edge after entering SEARCH.
  - When LOCKED, h_cnt reaching H_TOTAL (missing hsync) is also a violation.
- Frame check: on each vsync assertion edge, the number of hsync edges since the previous vsync edge must equal V_TOTAL.
- FSM:
  - SEARCH: the first vsync assertion edge moves to VERIFY and clears the frame-error flag.
  - VERIFY:
    - Any line violation sets the frame-error flag.
    - At the next vsync edge, a clean frame (no error and line count == V_TOTAL) moves to LOCKED.
    - Otherwise stay in VERIFY and clear the flag.
  - LOCKED:
    - A line or frame violation pulses line_err, returns to SEARCH and drops locked in the same clk.
    - The accumulator is discarded; no sum_valid is issued.
  - locked = 1 exactly while in the LOCKED state.
- Checksum:
  - The 16-bit accumulator adds {r,g,b} (zero-extended) for every active-window pixel, modulo 2^16.
  - On a clean vsync edge while LOCKED: frame_sum <= accumulator including the current tick, sum_valid pulses, and frame_count increments (wraps from 0xFFFF to 0).
  - The accumulator clears on every vsync assertion edge in every state.
- Reset asserted mid-frame forces the reset values immediately; there is no partial frame output.
- Simultaneous line_err and frame completion: the error wins, and sum_valid is not issued.

Test Plan:
- Ideal 640x480 timing, p_tick every 4th clk, all pixels 0xFFF -> locked rises at the 2nd vsync edge. Each later frame gives sum_valid with frame_sum=0x5000, and frame_count goes 1,2,3.
- Only pixel (0,0)=0x123, rest black, locked -> exactly one pix_valid with pix_x=0, pix_y=0, pix_rgb=0x123, and frame_sum=0x0123.
- Locked, one line stretched to 801 ticks -> line_err pulses once, locked falls that clk, no sum_valid for that frame. Relock after 2 further clean vsync edges.
- Frame with 524 lines while LOCKED -> line_err at the vsync edge and return to SEARCH; frame_count unchanged.
- Hsync held deasserted for 900 ticks while locked -> line_err when h_cnt hits 800, then SEARCH.
- reset=0 mid-frame for 3 clks -> all outputs 0, and relock needs 2 clean vsync edges.
- SYNC_ACTIVE_LOW=0 with inverted syncs -> same results as the first scenario.
